// File: rtl/link_pkg.sv
// -----------------------------------------------------------------------------
// link_pkg
// Shared types and default timing for the two-board remote key link.
//  - tx_state_t : per-channel TX sequencer state (IDLE -> PULSE -> GAP)
//  - DEF_*      : default timings, 1 ms granularity at 65 MHz
//  - max2       : helper used to size the shared TX down-counter
// -----------------------------------------------------------------------------
package link_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_PULSE = 2'd1,
      TX_GAP   = 2'd2
   } tx_state_t;

   localparam int DEF_PULSE_CYC   = 65_000;
   localparam int DEF_GAP_CYC     = 65_000;
   localparam int DEF_MIN_RX_CYC  = 32_500;
   localparam int DEF_MAX_RX_CYC  = 97_500;
   localparam int DEF_SYNC_STAGES = 2;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/link_chan.sv
// -----------------------------------------------------------------------------
// link_chan
// One link channel: a TX pulse sequencer with a depth-1 pending slot, and an
// RX qualifier that synchronises the remote wire and accepts only pulses whose
// high width falls in [MIN_RX_CYC, MAX_RX_CYC].
// Ports:
//  clk65MHz     in   system clock
//  rst          in   asynchronous active-high reset
//  req          in   1-cycle TX event request (already OR-ed across sources)
//  rx_pin       in   asynchronous remote wire
//  tx           out  registered TX wire
//  tx_busy      out  TX sequencer not idle
//  tx_overflow  out  1-cycle strobe: request merged into an already pending one
//  rx_evt       out  1-cycle strobe: valid remote pulse received
// -----------------------------------------------------------------------------
module link_chan
   import link_pkg::*;
#(
   parameter int PULSE_CYC   = DEF_PULSE_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC,
   parameter int MIN_RX_CYC  = DEF_MIN_RX_CYC,
   parameter int MAX_RX_CYC  = DEF_MAX_RX_CYC,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk65MHz,
   input  logic rst,
   input  logic req,
   input  logic rx_pin,
   output logic tx,
   output logic tx_busy,
   output logic tx_overflow,
   output logic rx_evt
);

   // ---------------------------------------------------------------- TX side
   localparam int TX_CW = $clog2(max2(PULSE_CYC, GAP_CYC) + 1);
   localparam logic [TX_CW-1:0] PULSE_LOAD = TX_CW'(PULSE_CYC - 1);
   localparam logic [TX_CW-1:0] GAP_LOAD   = TX_CW'(GAP_CYC - 1);

   tx_state_t        state;
   logic [TX_CW-1:0] tx_cnt;
   logic             pending;

   assign tx_busy = (state != TX_IDLE);

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values; later assignments in the block win.
   always_ff @(posedge clk65MHz or posedge rst) begin
      if (rst) begin
         state       <= TX_IDLE;
         tx_cnt      <= '0;
         pending     <= 1'b0;
         tx          <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         tx_overflow <= 1'b0;
         case (state)
            TX_IDLE: begin
               if (req || pending) begin
                  state   <= TX_PULSE;
                  tx      <= 1'b1;
                  tx_cnt  <= PULSE_LOAD;
                  pending <= 1'b0;
               end
            end
            TX_PULSE: begin
               if (tx_cnt == '0) begin
                  state  <= TX_GAP;
                  tx     <= 1'b0;
                  tx_cnt <= GAP_LOAD;
               end else begin
                  tx_cnt <= tx_cnt - TX_CW'(1);
               end
            end
            TX_GAP: begin
               if (tx_cnt == '0) begin
                  // A queued event launches right as the gap completes, so the
                  // low time stays exactly GAP_CYC with no extra idle cycle.
                  if (pending) begin
                     state   <= TX_PULSE;
                     tx      <= 1'b1;
                     tx_cnt  <= PULSE_LOAD;
                     pending <= 1'b0;
                  end else begin
                     state <= TX_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt - TX_CW'(1);
               end
            end
            default: begin
               state <= TX_IDLE;
               tx    <= 1'b0;
            end
         endcase

         // Requests arriving while busy queue once; a further one is merged.
         if (req && (state != TX_IDLE)) begin
            if (pending) tx_overflow <= 1'b1;
            else         pending     <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- RX side
   localparam int RX_CW = $clog2(MAX_RX_CYC + 2);
   localparam logic [RX_CW-1:0] RX_MIN = RX_CW'(MIN_RX_CYC);
   localparam logic [RX_CW-1:0] RX_MAX = RX_CW'(MAX_RX_CYC);
   localparam logic [RX_CW-1:0] RX_SAT = RX_CW'(MAX_RX_CYC + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] primed_q;  // marks which sync stages hold real samples
   logic                   lvl_prev;
   logic                   armed;     // a genuine low level has been observed
   logic [RX_CW-1:0]       rx_cnt;
   logic                   lvl;

   assign lvl = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk65MHz or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         primed_q <= '0;
         lvl_prev <= 1'b0;
         armed    <= 1'b0;
         rx_cnt   <= '0;
         rx_evt   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_pin};
         primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
         lvl_prev <= lvl;
         rx_evt   <= 1'b0;

         // The reset zeros in the chain are not a real low, so a line that is
         // already high at release cannot arm the qualifier until it drops.
         if (primed_q[SYNC_STAGES-1] && !lvl) armed <= 1'b1;

         // The rise cycle is the first high cycle, so the count restarts at 1.
         if (lvl && !lvl_prev)
            rx_cnt <= RX_CW'(1);
         else if (lvl && (rx_cnt != RX_SAT))
            rx_cnt <= rx_cnt + RX_CW'(1);

         if (!lvl && lvl_prev && armed && (rx_cnt >= RX_MIN) && (rx_cnt <= RX_MAX))
            rx_evt <= 1'b1;
      end
   end

endmodule

// File: rtl/remote_link_ctrl.sv
// -----------------------------------------------------------------------------
// remote_link_ctrl
// Schedules the two-board remote key link: merges keyboard and button events
// per channel and maps the SPACE and ENTER link channels onto the board pins.
// Ports:
//  clk65MHz                    in   system/pixel clock
//  rst                         in   asynchronous active-high reset
//  kbd_space_req/kbd_enter_req in   1-cycle keyboard event strobes
//  btn_space_req/btn_enter_req in   1-cycle button event strobes
//  SPACE_RX/ENTER_RX           in   asynchronous remote wires
//  SPACE_TX/ENTER_TX           out  registered wires to remote board
//  rx_space_evt/rx_enter_evt   out  1-cycle valid remote event strobes
//  tx_busy[1:0]                out  [0]=SPACE, [1]=ENTER sequencer not idle
//  tx_overflow[1:0]            out  per-channel merged-event strobe
// -----------------------------------------------------------------------------
module remote_link_ctrl
   import link_pkg::*;
#(
   parameter int PULSE_CYC   = DEF_PULSE_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC,
   parameter int MIN_RX_CYC  = DEF_MIN_RX_CYC,
   parameter int MAX_RX_CYC  = DEF_MAX_RX_CYC,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic       clk65MHz,
   input  logic       rst,
   input  logic       kbd_space_req,
   input  logic       kbd_enter_req,
   input  logic       btn_space_req,
   input  logic       btn_enter_req,
   input  logic       SPACE_RX,
   input  logic       ENTER_RX,
   output logic       SPACE_TX,
   output logic       ENTER_TX,
   output logic       rx_space_evt,
   output logic       rx_enter_evt,
   output logic [1:0] tx_busy,
   output logic [1:0] tx_overflow
);

   logic space_req;
   logic enter_req;

   // Simultaneous keyboard and button strobes collapse into one event.
   assign space_req = kbd_space_req | btn_space_req;
   assign enter_req = kbd_enter_req | btn_enter_req;

   link_chan #(
      .PULSE_CYC  (PULSE_CYC),
      .GAP_CYC    (GAP_CYC),
      .MIN_RX_CYC (MIN_RX_CYC),
      .MAX_RX_CYC (MAX_RX_CYC),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_space (
      .clk65MHz   (clk65MHz),
      .rst        (rst),
      .req        (space_req),
      .rx_pin     (SPACE_RX),
      .tx         (SPACE_TX),
      .tx_busy    (tx_busy[0]),
      .tx_overflow(tx_overflow[0]),
      .rx_evt     (rx_space_evt)
   );

   link_chan #(
      .PULSE_CYC  (PULSE_CYC),
      .GAP_CYC    (GAP_CYC),
      .MIN_RX_CYC (MIN_RX_CYC),
      .MAX_RX_CYC (MAX_RX_CYC),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_enter (
      .clk65MHz   (clk65MHz),
      .rst        (rst),
      .req        (enter_req),
      .rx_pin     (ENTER_RX),
      .tx         (ENTER_TX),
      .tx_busy    (tx_busy[1]),
      .tx_overflow(tx_overflow[1]),
      .rx_evt     (rx_enter_evt)
   );

endmodule

// File: tb/tb_remote_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_remote_link_ctrl
// Directed bench for remote_link_ctrl with short timings
// (PULSE=4, GAP=3, RX width window [2,6], 2-stage sync).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_remote_link_ctrl;

   logic       clk65MHz = 1'b0;
   logic       rst;
   logic       kbd_space_req, kbd_enter_req, btn_space_req, btn_enter_req;
   logic       SPACE_RX, ENTER_RX;
   logic       SPACE_TX, ENTER_TX;
   logic       rx_space_evt, rx_enter_evt;
   logic [1:0] tx_busy, tx_overflow;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk65MHz = ~clk65MHz;

   remote_link_ctrl #(
      .PULSE_CYC  (4),
      .GAP_CYC    (3),
      .MIN_RX_CYC (2),
      .MAX_RX_CYC (6),
      .SYNC_STAGES(2)
   ) dut (
      .clk65MHz     (clk65MHz),
      .rst          (rst),
      .kbd_space_req(kbd_space_req),
      .kbd_enter_req(kbd_enter_req),
      .btn_space_req(btn_space_req),
      .btn_enter_req(btn_enter_req),
      .SPACE_RX     (SPACE_RX),
      .ENTER_RX     (ENTER_RX),
      .SPACE_TX     (SPACE_TX),
      .ENTER_TX     (ENTER_TX),
      .rx_space_evt (rx_space_evt),
      .rx_enter_evt (rx_enter_evt),
      .tx_busy      (tx_busy),
      .tx_overflow  (tx_overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk65MHz);
      #1;
   endtask

   task automatic all_zero(input string tag);
      check(tag, {SPACE_TX, ENTER_TX, rx_space_evt, rx_enter_evt, tx_busy, tx_overflow}, 32'h0);
   endtask

   // Holds a wire high for `width` cycles, then watches 6 cycles after the fall
   // and expects a strobe only on the 3rd one when `expect_evt` is set.
   task automatic rx_pulse(input string tag, input int width, input bit on_space,
                           input bit on_enter, input bit expect_evt);
      SPACE_RX = on_space;
      ENTER_RX = on_enter;
      repeat (width) tick();
      SPACE_RX = 1'b0;
      ENTER_RX = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (on_space) check({tag, "_space"}, rx_space_evt, on_space && expect_evt && (i == 3));
         if (on_enter) check({tag, "_enter"}, rx_enter_evt, on_enter && expect_evt && (i == 3));
      end
      repeat (3) tick();
   endtask

   initial begin
      rst = 1'b1;
      kbd_space_req = 1'b0; kbd_enter_req = 1'b0;
      btn_space_req = 1'b0; btn_enter_req = 1'b0;
      SPACE_RX = 1'b0; ENTER_RX = 1'b0;
      repeat (3) tick();
      all_zero("reset_outputs");
      rst = 1'b0;
      repeat (4) tick();
      all_zero("idle_after_reset");

      // 1: single keyboard SPACE event
      kbd_space_req = 1'b1;
      tick();
      kbd_space_req = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check("t1_space_tx", SPACE_TX, i < 4);
         check("t1_busy0", tx_busy[0], i < 7);
         check("t1_enter_tx", ENTER_TX, 1'b0);
         tick();
      end

      // 2: keyboard + button ENTER in the same cycle -> one pulse
      kbd_enter_req = 1'b1;
      btn_enter_req = 1'b1;
      tick();
      kbd_enter_req = 1'b0;
      btn_enter_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check("t2_enter_tx", ENTER_TX, i < 4);
         check("t2_busy1", tx_busy[1], i < 7);
         check("t2_ovf", tx_overflow, 2'b00);
         tick();
      end

      // 3: requests at k, k+2, k+3 -> pulses at k and k+7, one overflow
      for (int i = 0; i < 16; i++) begin
         kbd_space_req = (i == 0) || (i == 2) || (i == 3);
         tick();
         kbd_space_req = 1'b0;
         check("t3_space_tx", SPACE_TX, (i <= 3) || ((i >= 7) && (i <= 10)));
         check("t3_ovf0", tx_overflow[0], i == 3);
         check("t3_busy0", tx_busy[0], i <= 13);
      end
      repeat (2) tick();

      // 4: RX width qualification
      rx_pulse("t4_w4", 4, 1'b1, 1'b0, 1'b1);
      rx_pulse("t4_w1", 1, 1'b1, 1'b0, 1'b0);
      rx_pulse("t4_w10", 10, 1'b1, 1'b0, 1'b0);
      rx_pulse("t4_w2min", 2, 1'b1, 1'b0, 1'b1);
      rx_pulse("t4_w6max", 6, 1'b1, 1'b0, 1'b1);
      rx_pulse("t4_w7", 7, 1'b1, 1'b0, 1'b0);

      // 5: both channels together
      kbd_space_req = 1'b1;
      btn_enter_req = 1'b1;
      tick();
      kbd_space_req = 1'b0;
      btn_enter_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("t5_space_tx", SPACE_TX, i < 4);
         check("t5_enter_tx", ENTER_TX, i < 4);
         check("t5_busy", tx_busy, (i < 7) ? 2'b11 : 2'b00);
         tick();
      end
      rx_pulse("t5_rx_both", 3, 1'b1, 1'b1, 1'b1);

      // 6: reset mid-pulse with pending set; RX line high across release
      kbd_space_req = 1'b1;
      tick();
      kbd_space_req = 1'b0;
      tick();
      kbd_space_req = 1'b1;
      tick();
      kbd_space_req = 1'b0;
      check("t6_pulse_before_rst", SPACE_TX, 1'b1);
      SPACE_RX = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("t6_tx_async_low", SPACE_TX, 1'b0);
      check("t6_busy_async", tx_busy, 2'b00);
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         all_zero("t6_after_release");
      end
      SPACE_RX = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         all_zero("t6_no_rx_no_tx");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
